mem_access: RTL and testbench

//  MEM pipeline stage. Sits between EX/MEM and the WB stage. Runs loads and stores

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/mem_access_align.sv | 44 ++++
 rtl/mem_access.sv | 130 +++++++++++++
 tb/tb_mem_access.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // MEM/WB pipeline register payload
  typedef struct packed {
    logic              mem_to_reg;
    logic              write_reg;
    logic [REG_AW-1:0] write_addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu_result;
  } memwb_t;

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        a,
  input  size_e             size,
  input  logic              zext,
  input  logic              store,
  input  logic [DATA_W-1:0] sd,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              mis
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{a, 3'b000} +: 8];
  assign half_lane = rdata[{a[1], 4'b0000} +: 16];

  always_comb begin
    be        = '1;
    wdata     = sd;
    load_data = rdata;
    mis       = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wdata     = {4{sd[7:0]}};
        load_data = zext ? DATA_W'(byte_lane) : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
        if (store) be = BE_W'(4'b0001 << a);
      end
      SIZE_HALF: begin
        mis       = a[0];
        wdata     = {2{sd[15:0]}};
        load_data = zext ? DATA_W'(half_lane) : {{(DATA_W-16){half_lane[15]}}, half_lane};
        if (store) be = a[1] ? 4'b1100 : 4'b0011;
      end
      default: mis = (a != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: req/ack data-memory access, upstream stall and the MEM/WB register.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_mem_read,
  input  logic              m_mem_write,
  input  logic              m_mem_to_reg,
  input  logic              m_write_reg,
  input  logic [REG_AW-1:0] m_write_addr,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_req,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic              w_mem_to_reg,
  output logic              w_write_reg,
  output logic [REG_AW-1:0] w_write_addr,
  output logic [DATA_W-1:0] data_from_mem,
  output logic [DATA_W-1:0] alu_result
);

  state_e            state, state_d;
  logic [TO_W-1:0]   cnt, cnt_d;
  memwb_t            memwb_q, memwb_d;
  logic              acc, mis, req_c, timeout_c, bubble_c;
  logic [DATA_W-1:0] load_data;

  assign acc = m_mem_read | m_mem_write;

  mem_access_align u_align (
    .a         (m_alu_result[1:0]),
    .size      (size_e'(m_size)),
    .zext      (m_unsigned),
    .store     (m_mem_write),
    .sd        (m_store_data),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .load_data (load_data),
    .mis       (mis)
  );

  // Next state, ack-wait counter and request decode
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    req_c     = 1'b0;
    timeout_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc && !mis) begin
          req_c = 1'b1;
          if (!dmem_ack) begin
            state_d = ST_WAIT;
            cnt_d   = TO_W'(1);
          end
        end
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if ((ACK_TIMEOUT != 0) && (cnt == TO_W'(ACK_TIMEOUT))) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A timed-out access releases upstream in its last cycle but still retires as a bubble
  assign bubble_c  = (acc && mis) || (req_c && !dmem_ack);
  assign dmem_req  = rst & req_c;
  assign dmem_we   = rst & req_c & m_mem_write;
  assign stall_req = rst & req_c & ~dmem_ack & ~timeout_c;
  assign dmem_addr = {m_alu_result[ADDR_W-1:2], 2'b00};

  always_comb begin
    memwb_d = '0;
    if (!bubble_c) begin
      memwb_d.mem_to_reg = m_mem_to_reg;
      memwb_d.write_reg  = m_write_reg;
      memwb_d.write_addr = m_write_addr;
      memwb_d.data       = load_data;
      memwb_d.alu_result = m_alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      memwb_q      <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      memwb_q      <= memwb_d;
      misalign_exc <= acc & mis;
      bus_err      <= timeout_c;
    end
  end

  assign w_mem_to_reg  = memwb_q.mem_to_reg;
  assign w_write_reg   = memwb_q.write_reg;
  assign w_write_addr  = memwb_q.write_addr;
  assign data_from_mem = memwb_q.data;
  assign alu_result    = memwb_q.alu_result;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed cases plus randomized loads/stores with random ack latency.
`timescale 1ns/1ps
module tb_mem_access;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_mem_read, m_mem_write, m_mem_to_reg, m_write_reg, m_unsigned;
  logic [4:0]  m_write_addr;
  logic [1:0]  m_size;
  logic [31:0] m_alu_result, m_store_data;
  logic        dmem_req, dmem_we, dmem_ack, stall_req, misalign_exc, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        w_mem_to_reg, w_write_reg;
  logic [4:0]  w_write_addr;
  logic [31:0] data_from_mem, alu_result;

  mem_access #(.ACK_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_mem_to_reg(m_mem_to_reg),
    .m_write_reg(m_write_reg), .m_write_addr(m_write_addr), .m_size(m_size),
    .m_unsigned(m_unsigned), .m_alu_result(m_alu_result), .m_store_data(m_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_req(stall_req),
    .misalign_exc(misalign_exc), .bus_err(bus_err), .w_mem_to_reg(w_mem_to_reg),
    .w_write_reg(w_write_reg), .w_write_addr(w_write_addr), .data_from_mem(data_from_mem),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we, stall, chk_be, chk_wd;
    logic [3:0]  be;
    logic [31:0] wdata, addr;
  } comb_exp_t;

  typedef struct {
    logic        wr, m2r, mexc, berr;
    logic [4:0]  waddr;
    logic [31:0] data, alu;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  int        checks = 0;
  int        passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference rules for alignment, lanes and load extension
  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a, input logic store);
    int off;
    off = int'(a % 4);
    if (!store || sz[1]) return 4'hF;
    if (sz == 2'b00) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'b00) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int          sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a % 4);
      v  = (rd >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      sh = 16 * int'((a % 4) / 2);
      v  = (rd >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drives one instruction in MEM until it retires; memory answers on cycle 'delay' of the access
  task automatic run_instr(input logic rd, input logic wr, input logic m2r, input logic wreg,
                           input logic [4:0] wa, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] sd, input int delay,
                           input logic [31:0] ack_data);
    logic      acc, mis, ackv, to_hit, done;
    logic [31:0] rdv;
    comb_exp_t ce;
    reg_exp_t  re;
    int        k;
    acc  = rd | wr;
    mis  = acc && is_mis(sz, a);
    k    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #2;
      m_mem_read = rd; m_mem_write = wr; m_mem_to_reg = m2r; m_write_reg = wreg;
      m_write_addr = wa; m_size = sz; m_unsigned = uns; m_alu_result = a; m_store_data = sd;
      if (acc && !mis) begin
        ackv = (k == delay);
        rdv  = ackv ? ack_data : $urandom;
      end else begin
        ackv = 1'($urandom);
        rdv  = ack_data;
      end
      dmem_ack = ackv; dmem_rdata = rdv;
      ce = '{req: 1'b0, we: 1'b0, stall: 1'b0, chk_be: 1'b0, chk_wd: 1'b0,
             be: 4'h0, wdata: 32'h0, addr: a & ~32'h3};
      re = '{wr: 1'b0, m2r: 1'b0, mexc: 1'b0, berr: 1'b0, waddr: 5'h0, data: 32'h0, alu: 32'h0};
      if (acc && !mis) begin
        to_hit    = !ackv && (TIMEOUT != 0) && (k == int'(TIMEOUT));
        ce.req    = 1'b1;
        ce.we     = wr;
        ce.stall  = !ackv && !to_hit;
        ce.chk_be = 1'b1;
        ce.be     = exp_be(sz, a, wr);
        ce.chk_wd = wr;
        ce.wdata  = exp_wdata(sz, sd);
        if (ackv) begin
          re.wr = wreg; re.m2r = m2r; re.waddr = wa; re.alu = a;
          re.data = load_fmt(sz, uns, a, rdv);
          done = 1'b1;
        end else if (to_hit) begin
          re.berr = 1'b1;
          done = 1'b1;
        end
        k++;
      end else begin
        if (mis) re.mexc = 1'b1;
        else begin
          re.wr = wreg; re.m2r = m2r; re.waddr = wa; re.alu = a;
          re.data = load_fmt(sz, uns, a, rdv);
        end
        done = 1'b1;
      end
      comb_q.push_back(ce);
      reg_q.push_back(re);
    end
  endtask

  // Monitor: registered outputs just after the edge, request-side outputs mid-cycle
  comb_exp_t mce;
  reg_exp_t  mre;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reg_q.size() > 0) begin
        mre = reg_q.pop_front();
        chk("w_write_reg",   32'(w_write_reg),  32'(mre.wr));
        chk("w_mem_to_reg",  32'(w_mem_to_reg), 32'(mre.m2r));
        chk("w_write_addr",  32'(w_write_addr), 32'(mre.waddr));
        chk("data_from_mem", data_from_mem,     mre.data);
        chk("alu_result",    alu_result,        mre.alu);
        chk("misalign_exc",  32'(misalign_exc), 32'(mre.mexc));
        chk("bus_err",       32'(bus_err),      32'(mre.berr));
      end
      #5;
      if (comb_q.size() > 0) begin
        mce = comb_q.pop_front();
        chk("dmem_req",  32'(dmem_req),  32'(mce.req));
        chk("dmem_we",   32'(dmem_we),   32'(mce.we));
        chk("stall_req", 32'(stall_req), 32'(mce.stall));
        chk("dmem_addr", dmem_addr,      mce.addr);
        if (mce.chk_be) chk("dmem_be",    32'(dmem_be), 32'(mce.be));
        if (mce.chk_wd) chk("dmem_wdata", dmem_wdata,   mce.wdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [1:0] r_op, r_sz;
  initial begin
    rst = 1'b0;
    m_mem_read = 1'b0; m_mem_write = 1'b0; m_mem_to_reg = 1'b0; m_write_reg = 1'b0;
    m_write_addr = 5'h0; m_size = 2'b00; m_unsigned = 1'b0; m_alu_result = 32'h0;
    m_store_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #3;
    chk("rst_req",   32'(dmem_req),     32'h0);
    chk("rst_stall", 32'(stall_req),    32'h0);
    chk("rst_wreg",  32'(w_write_reg),  32'h0);
    chk("rst_data",  data_from_mem,     32'h0);
    chk("rst_mexc",  32'(misalign_exc), 32'h0);
    chk("rst_berr",  32'(bus_err),      32'h0);
    #20 rst = 1'b1;

    run_instr(1, 0, 1, 1, 5'd3, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    run_instr(1, 0, 1, 1, 5'd4, 2'b00, 0, 32'h103, 32'h0, 3, 32'h80FF_FFFF);
    run_instr(1, 0, 1, 1, 5'd4, 2'b00, 1, 32'h103, 32'h0, 3, 32'h80FF_FFFF);
    run_instr(0, 1, 0, 0, 5'd0, 2'b01, 0, 32'h102, 32'h1234_ABCD, 1, 32'h0);
    run_instr(1, 0, 1, 1, 5'd7, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0);
    run_instr(1, 0, 1, 1, 5'd8, 2'b10, 0, 32'h104, 32'h0, 1000, 32'h0);
    run_instr(1, 0, 1, 1, 5'd9, 2'b01, 0, 32'h106, 32'h0, 4, 32'h8001_7FFF);
    run_instr(0, 0, 0, 1, 5'd10, 2'b10, 0, 32'h1234_5678, 32'h0, 0, 32'hCAFE_F00D);
    run_instr(1, 1, 0, 0, 5'd11, 2'b00, 0, 32'h201, 32'h0000_00A5, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_sz = 2'($urandom_range(0, 3));
      run_instr(r_op[0], r_op[1], 1'($urandom), 1'($urandom), 5'($urandom), r_sz,
                1'($urandom), 32'h100 + ($urandom & 32'hFF), $urandom,
                $urandom_range(0, 6), $urandom);
    end

    // Reset asserted while a load is waiting for its ack
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      m_mem_read = 1'b1; m_mem_write = 1'b0; m_mem_to_reg = 1'b1; m_write_reg = 1'b1;
      m_write_addr = 5'd12; m_size = 2'b10; m_unsigned = 1'b0; m_alu_result = 32'h300;
      dmem_ack = 1'b0;
      comb_q.push_back('{req: 1'b1, we: 1'b0, stall: 1'b1, chk_be: 1'b1, chk_wd: 1'b0,
                         be: 4'hF, wdata: 32'h0, addr: 32'h300});
      reg_q.push_back('{wr: 1'b0, m2r: 1'b0, mexc: 1'b0, berr: 1'b0, waddr: 5'h0,
                        data: 32'h0, alu: 32'h0});
    end
    @(posedge clk); #3;
    chk("wait_req_before_rst", 32'(dmem_req), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req",   32'(dmem_req),     32'h0);
    chk("midrst_stall", 32'(stall_req),    32'h0);
    chk("midrst_we",    32'(dmem_we),      32'h0);
    chk("midrst_wreg",  32'(w_write_reg),  32'h0);
    chk("midrst_m2r",   32'(w_mem_to_reg), 32'h0);
    chk("midrst_waddr", 32'(w_write_addr), 32'h0);
    chk("midrst_data",  data_from_mem,     32'h0);
    chk("midrst_alu",   alu_result,        32'h0);
    m_mem_read = 1'b0; m_write_reg = 1'b0; m_mem_to_reg = 1'b0;
    @(posedge clk); #4 rst = 1'b1;

    run_instr(1, 0, 1, 1, 5'd13, 2'b10, 0, 32'h300, 32'h0, 2, 32'h1357_9BDF);
    run_instr(1, 0, 1, 1, 5'd14, 2'b01, 1, 32'h302, 32'h0, 0, 32'hF00D_1234);

    repeat (2) @(posedge clk);
    #8;
    chk("reg_q_drained",  32'(reg_q.size()),  32'h0);
    chk("comb_q_drained", 32'(comb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
